// File: rtl/ascii_num_field_seq.sv
// ascii_num_field_seq: turns an ASCII command byte stream into decimal
// numbers tagged with their token index within the line. Non-numeric
// tokens are skipped but still advance the token index, so the decoder
// can pair each number with the keyword in front of it.
module ascii_num_field_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int FIELD_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIN_WIDTH-1:0] num_value,
  output logic [FIELD_W-1:0]   num_field,
  output logic                 num_overflow,
  output logic                 num_valid,
  input  logic                 num_ready,
  output logic                 line_end
);

  // Accumulator is extended by four bits so that acc*10+digit never
  // truncates before the overflow test.
  localparam int ACC_W = BIN_WIDTH + 4;

  // Whitespace codes: space, tab and CR (CR is plain whitespace here).
  localparam logic [23:0] SEP_CODES = {8'h20, 8'h09, 8'h0D};

  typedef enum logic [1:0] {
    IDLE,
    NUM,
    WORD,
    EMIT
  } state_t;

  state_t                 state_reg, state_next;
  logic [BIN_WIDTH-1:0]   acc_reg, acc_next;
  logic                   ovf_reg, ovf_next;
  logic [FIELD_W-1:0]     field_reg, field_next;
  logic                   eol_pend_reg, eol_pend_next;
  logic [BIN_WIDTH-1:0]   value_reg, value_next;
  logic [FIELD_W-1:0]     vfield_reg, vfield_next;
  logic                   vovf_reg, vovf_next;
  logic                   line_end_reg, line_end_next;

  logic                   is_digit;
  logic                   is_sep;
  logic                   is_eol;
  logic [2:0]             sep_hits;
  logic                   take;
  logic [ACC_W-1:0]       acc_ext;
  logic [ACC_W-1:0]       prod;
  logic                   prod_ovf;
  logic [FIELD_W-1:0]     field_inc;

  // One comparator per whitespace code.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sep
      assign sep_hits[gi] = (in_data == SEP_CODES[gi*8 +: 8]);
    end
  endgenerate

  assign is_sep   = |sep_hits;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_eol   = (in_data == 8'h0A);

  // Nothing is consumed while a finished number waits for the decoder.
  assign in_ready = (state_reg != EMIT);
  assign take     = in_valid && in_ready;

  // acc*10 + digit as (acc<<3) + (acc<<1) + digit at the widened size.
  assign acc_ext  = ACC_W'(acc_reg);
  assign prod     = (acc_ext << 3) + (acc_ext << 1) + ACC_W'(in_data[3:0]);
  assign prod_ovf = |prod[ACC_W-1:BIN_WIDTH];

  // Token index saturates at its maximum instead of wrapping.
  assign field_inc = (field_reg == {FIELD_W{1'b1}}) ? field_reg
                                                    : field_reg + FIELD_W'(1);

  // Next-state logic: classify the accepted byte and update the token tracker.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    ovf_next      = ovf_reg;
    field_next    = field_reg;
    eol_pend_next = eol_pend_reg;
    value_next    = value_reg;
    vfield_next   = vfield_reg;
    vovf_next     = vovf_reg;
    line_end_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            acc_next   = BIN_WIDTH'(in_data[3:0]);
            ovf_next   = 1'b0;
            state_next = NUM;
          end else if (is_eol) begin
            line_end_next = 1'b1;
            field_next    = '0;
          end else if (!is_sep) begin
            state_next = WORD;
          end
        end
      end

      NUM: begin
        if (take) begin
          if (is_digit) begin
            if (prod_ovf) begin
              acc_next = '1;
              ovf_next = 1'b1;
            end else begin
              acc_next = prod[BIN_WIDTH-1:0];
            end
          end else if (is_sep || is_eol) begin
            value_next    = acc_reg;
            vfield_next   = field_reg;
            vovf_next     = ovf_reg;
            eol_pend_next = is_eol;
            state_next    = EMIT;
          end else begin
            // A letter after digits makes the whole token a word ("1a").
            state_next = WORD;
          end
        end
      end

      WORD: begin
        if (take) begin
          if (is_sep) begin
            field_next = field_inc;
            state_next = IDLE;
          end else if (is_eol) begin
            line_end_next = 1'b1;
            field_next    = '0;
            state_next    = IDLE;
          end
        end
      end

      EMIT: begin
        if (num_ready) begin
          if (eol_pend_reg) begin
            line_end_next = 1'b1;
            field_next    = '0;
          end else begin
            field_next = field_inc;
          end
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset drops any token or pending number.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
      field_reg    <= '0;
      eol_pend_reg <= 1'b0;
      value_reg    <= '0;
      vfield_reg   <= '0;
      vovf_reg     <= 1'b0;
      line_end_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      ovf_reg      <= ovf_next;
      field_reg    <= field_next;
      eol_pend_reg <= eol_pend_next;
      value_reg    <= value_next;
      vfield_reg   <= vfield_next;
      vovf_reg     <= vovf_next;
      line_end_reg <= line_end_next;
    end
  end

  assign num_valid    = (state_reg == EMIT);
  assign num_value    = value_reg;
  assign num_field    = vfield_reg;
  assign num_overflow = vovf_reg;
  assign line_end     = line_end_reg;

endmodule

// File: tb/tb_ascii_num_field_seq.sv
// Scoreboard bench for ascii_num_field_seq: expected numbers are queued as
// each stimulus line is driven and compared at every num handshake.
module tb_ascii_num_field_seq;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] num_value;
  logic [2:0]  num_field;
  logic        num_overflow;
  logic        num_valid;
  logic        num_ready;
  logic        line_end;

  typedef struct packed {
    logic [15:0] v;
    logic [2:0]  f;
    logic        o;
    logic        e;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int le_count = 0;
  int hs_cyc = 0;
  logic le_pend = 1'b0;
  logic le_exp = 1'b0;

  ascii_num_field_seq #(.BIN_WIDTH(16), .FIELD_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .num_value    (num_value),
    .num_field    (num_field),
    .num_overflow (num_overflow),
    .num_valid    (num_valid),
    .num_ready    (num_ready),
    .line_end     (line_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v, input int f, input bit o, input bit e);
    exp_t x;
    x.v = 16'(v);
    x.f = 3'(f);
    x.o = o;
    x.e = e;
    exp_q.push_back(x);
  endtask

  // Output monitor: pops the scoreboard at each handshake and checks the
  // line_end pulse on the following cycle.
  always @(negedge clk) begin
    exp_t x;
    if (le_pend) begin
      check("line_end_after_hs", line_end, le_exp);
      le_pend = 1'b0;
    end
    if (line_end) le_count++;
    if (num_valid && num_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_num", exp_q.size(), 1);
      end else begin
        x = exp_q.pop_front();
        $display("num value=%0d field=%0d ovf=%0d", num_value, num_field, num_overflow);
        check("num_value", num_value, x.v);
        check("num_field", num_field, x.f);
        check("num_overflow", num_overflow, x.o);
        le_exp  = x.e;
        le_pend = 1'b1;
        hs_cyc  = cyc;
      end
    end
  end

  task automatic send(input logic [7:0] b, output int acc_cyc);
    logic rdy;
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    acc_cyc = -1;
    while (1) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc = cyc;
        break;
      end
      n++;
      if (n > 100) begin
        check("send_timeout", n, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    int c;
    for (int i = 0; i < s.len(); i++) send(s[i], c);
  endtask

  task automatic drain(input string tag, input int le_before, input int le_want);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_line_end_count"}, le_count - le_before, le_want);
  endtask

  initial begin
    int le0;
    int acc_cyc;
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    num_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_num_valid", num_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_num_value", num_value, 0);
    check("rst_num_field", num_field, 0);
    check("rst_num_overflow", num_overflow, 0);
    check("rst_line_end", line_end, 0);
    @(posedge clk);
    #1;

    // Keyword then number terminated by EOL, then a fresh line.
    le0 = le_count;
    push(12, 1, 0, 1);
    push(7, 0, 0, 0);
    send_str("depth 12\n7 \n");
    drain("t1", le0, 2);

    // Boundary value, first overflow, sticky overflow.
    le0 = le_count;
    push(65535, 0, 0, 0);
    push(65535, 1, 1, 0);
    push(65535, 2, 1, 1);
    send_str("65535 65536 999999\n");
    drain("t2", le0, 1);

    // Words and mixed tokens are skipped but counted.
    le0 = le_count;
    push(7, 1, 0, 0);
    push(5, 3, 0, 0);
    send_str("e2e4 7 1a 5 \n");
    drain("t3", le0, 1);

    // Consumer stalls 5 cycles; the next byte must wait for the handshake.
    le0 = le_count;
    num_ready = 1'b0;
    push(42, 0, 0, 0);
    send_str("42 ");
    fork
      send(8'h0A, acc_cyc);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_num_valid", num_valid, 1);
          check("stall_in_ready", in_ready, 0);
          check("stall_num_value", num_value, 42);
        end
        @(posedge clk);
        #1;
        num_ready = 1'b1;
      end
    join
    check("stall_valid_dropped", num_valid, 0);
    check("stall_byte_accept_cycle", acc_cyc, hs_cyc + 2);
    drain("t4", le0, 1);

    // Tabs and CR are whitespace; runs of them collapse.
    le0 = le_count;
    push(9, 0, 0, 0);
    push(8, 1, 0, 0);
    send_str("  9\011\0118\015\n");
    drain("t5", le0, 1);

    // Token index saturates at 7.
    le0 = le_count;
    push(1, 7, 0, 0);
    push(2, 7, 0, 1);
    send_str("a b c d e f g h 1 2\n");
    drain("t6", le0, 1);

    // Reset mid-number drops it entirely.
    le0 = le_count;
    send_str("12");
    reset = 1'b1;
    @(negedge clk);
    check("midrst_num_valid", num_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_num_value", num_value, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(3, 0, 0, 0);
    send_str(" 3 \n");
    drain("t7", le0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_num_field_seq.md
# ascii_num_field_seq

Sequencer in the UCI receive path that turns the ASCII command byte stream into decimal numeric arguments. It classifies each byte and drives a multiply-by-ten-and-add accumulator. It tracks token position within the line and presents each completed number, with its field index, to the command decoder over a valid/ready handshake. Non-numeric tokens such as `go`, `wtime` or `e2e4` are skipped but still counted, so the decoder can pair each value with the keyword before it.

## Interface
- BIN_WIDTH, 16, width of accumulated and emitted value
- FIELD_W, 3, width of token index within a line
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- num_value  out  BIN_WIDTH  completed number
- num_field  out  FIELD_W  token index of num_value within its line (0 = first token)
- num_overflow  out  1  value exceeded 2^BIN_WIDTH-1; num_value saturated
- num_valid  out  1  number presented
- num_ready  in  1  consumer accepts when num_valid & num_ready
- line_end  out  1  one-cycle pulse marking end of line

## Operation
- Byte classes:
  - DIGIT: 0x30-0x39.
  - SEP: 0x20, 0x09, 0x0D (CR is treated as whitespace).
  - EOL: 0x0A.
  - OTHER: everything else.
- States: IDLE (between tokens), NUM (accumulating digits), WORD (skipping a non-numeric token), EMIT (number held for consumer).
- IDLE:
  - DIGIT: acc=digit, ovf=0, go to NUM.
  - OTHER: go to WORD.
  - SEP: stay.
  - EOL: pulse line_end, field=0.
- NUM:
  - DIGIT: acc=acc*10+digit, computed at BIN_WIDTH+4 bits. If the result exceeds 2^BIN_WIDTH-1, set ovf sticky and hold acc at all-ones.
  - SEP: load outputs, eol_pend=0, go to EMIT.
  - EOL: load outputs, eol_pend=1, go to EMIT.
  - OTHER: discard acc and go to WORD. Mixed tokens like "1a" are words.
- WORD:
  - DIGIT or OTHER: stay.
  - SEP: field++, go to IDLE.
  - EOL: pulse line_end, field=0, go to IDLE.
- EMIT: num_valid=1; num_value, num_field and num_overflow are stable. On num_ready:
  - eol_pend=0: field++, go to IDLE.
  - eol_pend=1: pulse line_end, field=0, go to IDLE.
- field saturates at 2^FIELD_W-1; it never wraps.
- in_ready = (state != EMIT). No byte is consumed while a number is pending.
- Consecutive SEP bytes collapse; an empty token never advances field.

## Timing
- Reset values:
  - state IDLE, acc 0, ovf 0, field 0, eol_pend 0.
  - num_valid 0, num_value 0, num_field 0, num_overflow 0, line_end 0.
  - in_ready 1.
- Reset asserted mid-token or in EMIT drops the pending number immediately. No num_valid or line_end is produced for it.
- One byte per cycle when in_ready is high.
- Latency: num_valid rises the cycle after the terminating byte is accepted. It stays high until the cycle of the handshake and falls the next cycle. Minimum stall is 1 cycle per number.
- line_end is registered, high for exactly one cycle:
  - From IDLE or WORD: the cycle after EOL is accepted.
  - From NUM: the cycle after the num handshake.
- num_field reflects field before the post-emit increment.
- num_ready without num_valid is ignored. in_valid in EMIT is not consumed; the upstream holds the byte.

## Test plan
- "depth 12\n", num_ready=1 -> one output 12, field 1, ovf 0; line_end next cycle after handshake. A following "7 " yields field 0.
- "65535 65536 " -> 65535 field 0 ovf 0; then 65535 field 1 ovf 1.
- "e2e4 7 1a 5 \n" -> outputs only 7 (field 1) and 5 (field 3); "e2e4" and "1a" produce no output; one line_end.
- "42 " then num_ready low 5 cycles -> num_valid held 6 cycles, value 42 stable, in_ready 0, next byte held then consumed on the cycle after the handshake.
- "  9\t\t8\r\n" -> 9 field 0, 8 field 1, single line_end; CR produces no line_end.
- "12" then reset pulse then " 3 " -> no output for 12; output 3 field 0, ovf 0.
